// File: rtl/sparse_pair_feeder_if.sv
// Handshake bundle between the vector source, the sparse pair feeder and the accumulator.
// The master modport is the side that supplies vectors and accepts pairs.
interface sparse_pair_feeder_if #(
  parameter int LANES = 4,
  parameter int DW    = 4,
  parameter int LW    = $clog2(LANES)
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_a;
  logic [LANES*DW-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_a;
  logic [DW-1:0]         out_b;
  logic [LW-1:0]         out_lane;
  logic                  out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_lane, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_lane, out_last
  );
endinterface

// File: rtl/sparse_pair_feeder.sv
// Drops zero-product lanes of an activation/weight vector and streams the survivors
// one per cycle to the accumulator, flagging the closing pair and counting skipped lanes.
module sparse_pair_feeder #(
  parameter int LANES = 4,
  parameter int DW    = 4,
  parameter int CW    = 16,
  parameter int LW    = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  sparse_pair_feeder_if.slave   bus,
  output logic [CW-1:0]         skip_cnt
);

  typedef enum logic [1:0] {IDLE, EMIT, ZERO} state_t;

  localparam int SW = CW + LW + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LANES*DW-1:0]   r_a;
  logic [LANES*DW-1:0]   r_b;
  logic [LANES-1:0]      r_mask;
  logic [CW-1:0]         r_skip;
  logic [LANES-1:0]      w_mask_in;
  logic [LANES-1:0]      w_rest;
  logic [LW-1:0]         w_k;
  logic                  w_last;

  function automatic logic [LANES-1:0] nz_mask(input logic [LANES*DW-1:0] a,
                                               input logic [LANES*DW-1:0] b);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      m[i] = (a[i*DW +: DW] != '0) && (b[i*DW +: DW] != '0);
    return m;
  endfunction

  function automatic logic [LW:0] zero_count(input logic [LANES-1:0] m);
    logic [LW:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++)
      c = c + (LW+1)'(!m[i]);
    return c;
  endfunction

  // Sticks at all-ones instead of wrapping so sparsity statistics never under-report.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic [LW:0] inc);
    logic [SW-1:0] s;
    s = SW'(cnt) + SW'(inc);
    if (s > SW'({CW{1'b1}}))
      return {CW{1'b1}};
    return s[CW-1:0];
  endfunction

  assign w_mask_in = nz_mask(bus.in_a, bus.in_b);
  assign skip_cnt  = r_skip;

  // Lowest remaining lane wins; scanning downward lets the last hit be the smallest index.
  always_comb begin
    w_k = '0;
    for (int i = LANES-1; i >= 0; i--)
      if (r_mask[i]) w_k = LW'(i);
  end

  assign w_rest = r_mask & ~(LANES'(1) << w_k);
  assign w_last = (w_rest == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.in_valid)            w_state_nxt = (w_mask_in != '0) ? EMIT : ZERO;
      EMIT: if (bus.out_ready && w_last) w_state_nxt = IDLE;
      ZERO: if (bus.out_ready)           w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mask <= '0;
      r_skip <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a    <= bus.in_a;
          r_b    <= bus.in_b;
          r_mask <= w_mask_in;
          r_skip <= sat_add(r_skip, zero_count(w_mask_in));
        end
        EMIT: if (bus.out_ready) r_mask <= w_rest;
        default: ;
      endcase
    end
  end

  // Pair outputs come only from registered state, never from in_*.
  always_comb begin
    bus.in_ready  = (r_state == IDLE) && !rst;
    bus.out_valid = (r_state != IDLE);
    bus.out_a     = '0;
    bus.out_b     = '0;
    bus.out_lane  = '0;
    bus.out_last  = 1'b0;
    unique case (r_state)
      EMIT: begin
        bus.out_a    = r_a[w_k*DW +: DW];
        bus.out_b    = r_b[w_k*DW +: DW];
        bus.out_lane = w_k;
        bus.out_last = w_last;
      end
      ZERO:    bus.out_last = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sparse_pair_feeder.sv
// Directed bench for sparse_pair_feeder: table of vectors with hand-computed pair streams,
// plus sequences for backpressure, mid-vector reset and skip-counter saturation.
module tb_sparse_pair_feeder;

  logic        clk;
  logic        rst;
  logic [15:0] skip;
  logic [2:0]  skip2;
  int          n_checks;
  int          n_fail;

  sparse_pair_feeder_if #(.LANES(4), .DW(4)) bus ();
  sparse_pair_feeder_if #(.LANES(4), .DW(4)) bus2 ();

  sparse_pair_feeder #(.LANES(4), .DW(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .skip_cnt(skip)
  );

  sparse_pair_feeder #(.LANES(4), .DW(4), .CW(3)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2), .skip_cnt(skip2)
  );

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    int               n;
    logic [3:0][3:0]  ea;
    logic [3:0][3:0]  eb;
    logic [3:0][1:0]  el;
    logic [15:0]      skip;
  } vec_t;

  vec_t vecs[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 1);
    chk({tag, " out_valid idle"}, 32'(bus.out_valid), 0);
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, " skip_cnt"}, 32'(skip), 32'(v.skip));
    chk({tag, " in_ready busy"}, 32'(bus.in_ready), 0);
    for (int p = 0; p < v.n; p++) begin
      chk($sformatf("%s p%0d valid", tag, p), 32'(bus.out_valid), 1);
      chk($sformatf("%s p%0d a", tag, p), 32'(bus.out_a), 32'(v.ea[p]));
      chk($sformatf("%s p%0d b", tag, p), 32'(bus.out_b), 32'(v.eb[p]));
      chk($sformatf("%s p%0d lane", tag, p), 32'(bus.out_lane), 32'(v.el[p]));
      chk($sformatf("%s p%0d last", tag, p), 32'(bus.out_last), (p == v.n-1) ? 1 : 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic sat_vec(input logic [15:0] a, input logic [15:0] b, input logic [2:0] exp_skip,
                         input string tag);
    logic [3:0] lo;
    lo = (b[3:0] != 4'd0) ? a[3:0] : 4'd0;
    bus2.in_a      = a;
    bus2.in_b      = b;
    bus2.in_valid  = 1'b1;
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk({tag, " skip_cnt"}, 32'(skip2), 32'(exp_skip));
    chk({tag, " valid"}, 32'(bus2.out_valid), 1);
    chk({tag, " last"}, 32'(bus2.out_last), 1);
    chk({tag, " a"}, 32'(bus2.out_a), 32'(lo));
    @(posedge clk); #1;
    chk({tag, " idle"}, 32'(bus2.out_valid), 0);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{a:16'h05DD, b:16'h700C, n:1, ea:16'h000D, eb:16'h000C, el:8'h00, skip:16'd3};
    vecs[1] = '{a:16'h4321, b:16'h1234, n:4, ea:16'h4321, eb:16'h1234, el:8'hE4, skip:16'd3};
    vecs[2] = '{a:16'h0000, b:16'hFFFF, n:1, ea:16'h0000, eb:16'h0000, el:8'h00, skip:16'd7};
    vecs[3] = '{a:16'h9060, b:16'h2508, n:1, ea:16'h0009, eb:16'h0002, el:8'h03, skip:16'd10};
    vecs[4] = '{a:16'h1101, b:16'h1111, n:3, ea:16'h0111, eb:16'h0111, el:8'h38, skip:16'd11};

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset in_ready", 32'(bus.in_ready), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset out_a", 32'(bus.out_a), 0);
    chk("reset out_lane", 32'(bus.out_lane), 0);
    chk("reset out_last", 32'(bus.out_last), 0);
    chk("reset skip_cnt", 32'(skip), 0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));
    chk("after table in_ready", 32'(bus.in_ready), 1);

    // Backpressure on lane1 with an all-zero vector offered meanwhile.
    bus.in_a = 16'h4321; bus.in_b = 16'h1234; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp lane0", 32'(bus.out_lane), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_a = 16'h0000; bus.in_b = 16'hFFFF; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp c%0d valid", c), 32'(bus.out_valid), 1);
      chk($sformatf("bp c%0d lane", c), 32'(bus.out_lane), 1);
      chk($sformatf("bp c%0d a", c), 32'(bus.out_a), 2);
      chk($sformatf("bp c%0d b", c), 32'(bus.out_b), 3);
      chk($sformatf("bp c%0d last", c), 32'(bus.out_last), 0);
      chk($sformatf("bp c%0d in_ready", c), 32'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp release lane", 32'(bus.out_lane), 1);
    chk("bp skip hold", 32'(skip), 11);
    @(posedge clk); #1;
    chk("bp lane2", 32'(bus.out_lane), 2);
    chk("bp lane2 a", 32'(bus.out_a), 3);
    @(posedge clk); #1;
    chk("bp lane3", 32'(bus.out_lane), 3);
    chk("bp lane3 last", 32'(bus.out_last), 1);
    @(posedge clk); #1;
    chk("bp done valid", 32'(bus.out_valid), 0);
    chk("bp done skip", 32'(skip), 11);

    // Reset while lane2 of a dense vector is pending.
    bus.in_a = 16'h4321; bus.in_b = 16'h1234; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst pre lane2", 32'(bus.out_lane), 2);
    rst = 1'b1;
    #1;
    chk("rst async valid", 32'(bus.out_valid), 0);
    chk("rst async skip", 32'(skip), 0);
    chk("rst async in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    v = vecs[0];
    run_vec(v, "post_rst");
    chk("post_rst in_ready", 32'(bus.in_ready), 1);

    // Saturation on the narrow-counter instance; the earlier reset left it at 0.
    sat_vec(16'h0000, 16'hFFFF, 3'd4, "sat1");
    sat_vec(16'h0000, 16'hFFFF, 3'd7, "sat2");
    sat_vec(16'h0001, 16'h1111, 3'd7, "sat3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_pair_feeder.md
Name: sparse_pair_feeder

Overview:
- Upstream stage of the full adder tree / accumulator.
- Accepts one vector of LANES activation/weight pairs and drops every lane whose product is zero (a==0 or b==0).
- Streams the surviving pairs one per cycle into the 4-bit adder/accumulator inputs and marks the final pair so the accumulator can close the dot product.
- Keeps a saturating count of skipped lanes for sparsity statistics.

Parameters:
- LANES, 4, pairs per input vector (>=2).
- DW, 4, operand width; matches the accumulator a/b inputs.
- CW, 16, width of the skip counter.
- LW, $clog2(LANES), lane-index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  feeder can accept a vector
- in_a  in  LANES*DW  activations; lane i at [i*DW +: DW]
- in_b  in  LANES*DW  weights; same packing
- out_valid  out  1  pair valid toward accumulator
- out_ready  in  1  accumulator accepts pair
- out_a  out  DW  activation of current pair
- out_b  out  DW  weight of current pair
- out_lane  out  LW  source lane of current pair
- out_last  out  1  current pair is the last one of the vector
- skip_cnt  out  CW  saturating count of skipped lanes since reset

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=0 while rst is high.
  - out_valid=0, out_a=0, out_b=0, out_lane=0, out_last=0, skip_cnt=0.
  - Latched vector and mask cleared.
- FSM states: IDLE, EMIT, ZERO.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch in_a/in_b and compute mask[i] = (a_i!=0)&&(b_i!=0).
  - Add popcount(~mask) to skip_cnt, saturating at 2^CW-1 and never wrapping.
  - mask!=0 -> EMIT; mask==0 -> ZERO.
- EMIT:
  - out_valid=1. The pair is the lowest set bit k of the remaining mask: out_a=a_k, out_b=b_k, out_lane=k.
  - out_last=1 iff k is the only remaining set bit.
  - On out_valid&out_ready, clear bit k. If out_last was 1 -> IDLE, otherwise stay in EMIT.
- ZERO:
  - out_valid=1 with out_a=0, out_b=0, out_lane=0, out_last=1.
  - Holds until out_ready, then -> IDLE.
  - Guarantees the accumulator sees a closing pair for an all-sparse vector.
- in_ready=0 in EMIT and ZERO. No new vector is accepted until the last handshake completes; the next accept is earliest on the cycle after it.
- Latency: the first pair is valid on the cycle after acceptance. A vector with n nonzero lanes takes max(n,1) pair cycles plus 1 IDLE cycle when out_ready is held high.
- Backpressure: while out_valid&!out_ready, out_a, out_b, out_lane and out_last hold stable. out_valid never deasserts without a handshake.
- in_valid asserted outside IDLE is ignored and does not change skip_cnt.
- Reset mid-vector: immediate return to IDLE. The remaining pairs are discarded, out_valid drops asynchronously, and skip_cnt clears.
- All pair outputs are driven from registers plus the priority-encoder mux. There is no combinational path from in_* to out_*.

Test Plan:
1. Single survivor: in_a lanes3..0={0,5,13,13}, in_b={7,0,0,12}, out_ready=1 -> one pair (13,12), out_lane=0, out_last=1, cycle after accept; skip_cnt=3; in_ready back to 1 on the following cycle.
2. Dense vector: in_a={4,3,2,1}, in_b={1,2,3,4} -> pairs lane0 (1,4), lane1 (2,3), lane2 (3,2), lane3 (4,1) on 4 consecutive cycles; out_last only on lane3; skip_cnt unchanged.
3. All-zero vector: in_a=0, in_b={15,15,15,15} -> single ZERO pair (0,0), out_lane=0, out_last=1; skip_cnt +=4.
4. Backpressure: dense vector with out_ready=0 for 3 cycles on lane1 -> lane1 outputs stable and out_valid=1 for 3 cycles; in_valid pulsed meanwhile is ignored; the sequence completes after release.
5. Reset mid-operation: assert rst while lane2 of a dense vector is pending -> out_valid=0 and skip_cnt=0 immediately. After release, in_ready=1 and the next vector is processed normally.
6. Saturation (CW=3): send two all-zero vectors, then a {0,0,0,1}/{1,1,1,1} vector -> skip_cnt goes 4, then 7 (saturated, not 0), then stays 7.
